// File: rtl/digit_value_renderer.sv
// rtl/digit_value_renderer.sv - binary value to a row of scaled seven-segment decimal glyphs in the pixel stream
module digit_value_renderer #(
    parameter int         VALUE_W    = 10,
    parameter int         NUM_DIGITS = 3,
    parameter int         SCALE_LOG2 = 1,
    parameter int         ORIGIN_X   = 0,
    parameter int         ORIGIN_Y   = 0,
    parameter int         LZ_BLANK   = 1,
    parameter logic [5:0] FG         = 6'b000000,
    parameter logic [5:0] BG         = 6'b111111
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [VALUE_W-1:0] value_in,
    input  logic               value_valid,
    output logic               value_ready,
    input  logic [9:0]         hcount,
    input  logic [9:0]         vcount,
    input  logic               pix_valid_in,
    output logic [5:0]         pixel,
    output logic               pix_valid_out
);

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam int BCD_W       = 4 * NUM_DIGITS;
    localparam int CNT_W       = $clog2(VALUE_W + 1);
    localparam int FIELD_W     = NUM_DIGITS * 8 * (1 << SCALE_LOG2);
    localparam int FIELD_H     = 16 * (1 << SCALE_LOG2);
    localparam logic [63:0] MAX_VAL = 64'(pow10(NUM_DIGITS) - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;

    // segment bits are {a,b,c,d,e,f,g}
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1111110;
            4'd1:    seg_decode = 7'b0110000;
            4'd2:    seg_decode = 7'b1101101;
            4'd3:    seg_decode = 7'b1111001;
            4'd4:    seg_decode = 7'b0110011;
            4'd5:    seg_decode = 7'b1011011;
            4'd6:    seg_decode = 7'b1011111;
            4'd7:    seg_decode = 7'b1110000;
            4'd8:    seg_decode = 7'b1111111;
            4'd9:    seg_decode = 7'b1111011;
            default: seg_decode = 7'b0000000;
        endcase
    endfunction

    function automatic logic seg_lit(input logic [6:0] seg, input logic [3:0] row, input logic [2:0] col);
        logic inner, left, right, upper, lower;
        inner = (col >= 3'd1) && (col <= 3'd6);
        left  = (col == 3'd1);
        right = (col == 3'd6);
        upper = (row >= 4'd1) && (row <= 4'd8);
        lower = (row >= 4'd8) && (row <= 4'd14);
        seg_lit = (seg[6] && inner && (row == 4'd1  || row == 4'd2))
               || (seg[0] && inner && (row == 4'd7  || row == 4'd8))
               || (seg[3] && inner && (row == 4'd13 || row == 4'd14))
               || (seg[1] && left  && upper)
               || (seg[5] && right && upper)
               || (seg[2] && left  && lower)
               || (seg[4] && right && lower);
    endfunction

    logic [1:0]         state_q, state_d;
    logic [VALUE_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [BCD_W-1:0]   disp_q, disp_d;
    logic               disp_ovf_q, disp_ovf_d;
    logic               frame_start;
    logic [63:0]        value_ext;

    assign frame_start = pix_valid_in && (hcount == 10'd0) && (vcount == 10'd0);
    assign value_ext   = 64'(value_in);
    assign value_ready = (state_q == ST_IDLE);

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        disp_d     = disp_q;
        disp_ovf_d = disp_ovf_q;
        bcd_adj    = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        case (state_q)
            ST_IDLE: begin
                if (value_valid) begin
                    bin_d   = value_in;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = (value_ext > MAX_VAL);
                    state_d = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                // digits beyond NUM_DIGITS fall off the top; such values are flagged as overflow anyway
                {bcd_d, bin_d} = {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(VALUE_W - 1)) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (frame_start) begin
                    disp_d     = bcd_q;
                    disp_ovf_d = ovf_q;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    logic [6:0] seg_tab [8];
    logic       lead;
    logic [3:0] digit;

    always_comb begin
        lead  = (LZ_BLANK != 0);
        digit = 4'd0;
        for (int k = 0; k < 8; k++) seg_tab[k] = 7'd0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            digit = disp_q[4*(NUM_DIGITS-1-k) +: 4];
            if (digit != 4'd0) lead = 1'b0;
            if (disp_ovf_q)                         seg_tab[k] = 7'b0000001;
            else if (lead && (k != NUM_DIGITS - 1)) seg_tab[k] = 7'd0;
            else                                    seg_tab[k] = seg_decode(digit);
        end
    end

    int         xoff, yoff;
    logic       s1_in_d;
    logic [2:0] s1_cell_d, s1_col_d;
    logic [3:0] s1_row_d;

    always_comb begin
        xoff      = int'({22'd0, hcount}) - ORIGIN_X;
        yoff      = int'({22'd0, vcount}) - ORIGIN_Y;
        s1_in_d   = (xoff >= 0) && (xoff < FIELD_W) && (yoff >= 0) && (yoff < FIELD_H);
        s1_cell_d = 3'(xoff >>> (3 + SCALE_LOG2));
        s1_col_d  = 3'(xoff >>> SCALE_LOG2);
        s1_row_d  = 4'(yoff >>> SCALE_LOG2);
    end

    logic       s1_valid_q, s1_in_q;
    logic [2:0] s1_cell_q, s1_col_q;
    logic [3:0] s1_row_q;
    logic [5:0] pixel_q, pixel_d;
    logic       pv2_q;

    always_comb begin
        pixel_d = BG;
        if (s1_valid_q && s1_in_q && seg_lit(seg_tab[s1_cell_q], s1_row_q, s1_col_q)) pixel_d = FG;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            disp_q     <= '0;
            disp_ovf_q <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_in_q    <= 1'b0;
            s1_cell_q  <= '0;
            s1_col_q   <= '0;
            s1_row_q   <= '0;
            pixel_q    <= BG;
            pv2_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            disp_q     <= disp_d;
            disp_ovf_q <= disp_ovf_d;
            s1_valid_q <= pix_valid_in;
            s1_in_q    <= s1_in_d;
            s1_cell_q  <= s1_cell_d;
            s1_col_q   <= s1_col_d;
            s1_row_q   <= s1_row_d;
            pixel_q    <= pixel_d;
            pv2_q      <= s1_valid_q;
        end
    end

    assign pixel         = pixel_q;
    assign pix_valid_out = pv2_q;

endmodule

// File: tb/tb_digit_value_renderer.sv
// tb/tb_digit_value_renderer.sv - directed bench for digit_value_renderer with and without leading-zero blanking
module tb_digit_value_renderer;
    localparam int         VW = 10;
    localparam logic [5:0] FG = 6'b000000;
    localparam logic [5:0] BG = 6'b111111;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [VW-1:0] value_in;
    logic          value_valid;
    logic          value_ready, value_ready_nz;
    logic [9:0]    hcount, vcount;
    logic          pix_valid_in;
    logic [5:0]    pixel, pixel_nz;
    logic          pix_valid_out, pix_valid_out_nz;
    int            n_checks = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    digit_value_renderer #(.VALUE_W(VW), .NUM_DIGITS(3), .SCALE_LOG2(0), .ORIGIN_X(0), .ORIGIN_Y(0),
                           .LZ_BLANK(1), .FG(FG), .BG(BG)) dut (
        .clk(clk), .reset_n(reset_n), .value_in(value_in), .value_valid(value_valid),
        .value_ready(value_ready), .hcount(hcount), .vcount(vcount), .pix_valid_in(pix_valid_in),
        .pixel(pixel), .pix_valid_out(pix_valid_out));

    digit_value_renderer #(.VALUE_W(VW), .NUM_DIGITS(3), .SCALE_LOG2(0), .ORIGIN_X(0), .ORIGIN_Y(0),
                           .LZ_BLANK(0), .FG(FG), .BG(BG)) dut_nz (
        .clk(clk), .reset_n(reset_n), .value_in(value_in), .value_valid(value_valid),
        .value_ready(value_ready_nz), .hcount(hcount), .vcount(vcount), .pix_valid_in(pix_valid_in),
        .pixel(pixel_nz), .pix_valid_out(pix_valid_out_nz));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input int x, input int y, output logic [5:0] p, output logic [5:0] pnz);
        hcount = 10'(x); vcount = 10'(y); pix_valid_in = 1'b1;
        cyc();
        pix_valid_in = 1'b0;
        cyc();
        p = pixel; pnz = pixel_nz;
    endtask

    task automatic load(input int v);
        int guard;
        guard = 0;
        while (!value_ready && guard < 50) begin cyc(); guard++; end
        value_in = VW'(v); value_valid = 1'b1;
        cyc();
        value_valid = 1'b0;
        repeat (VW) cyc();
        hcount = 10'd0; vcount = 10'd0; pix_valid_in = 1'b1;
        cyc();
        guard = 1;
        while (!value_ready && guard < 8) begin cyc(); guard++; end
        pix_valid_in = 1'b0;
        n_checks++;
        if (value_ready !== 1'b1) begin
            n_fail++; $display("FAIL load_commit v=%0d: value_ready=%b required 1", v, value_ready);
        end
    endtask

    task automatic test_reset();
        logic [5:0] p, pnz;
        int px[2] = '{17, 1};
        logic [5:0] ep[2] = '{FG, BG};
        logic [5:0] en[2] = '{FG, FG};
        reset_n = 1'b1; value_valid = 1'b0; value_in = '0;
        hcount = 10'd17; vcount = 10'd1; pix_valid_in = 1'b1;
        #2 reset_n = 1'b0;
        repeat (3) begin
            cyc();
            n_checks++;
            if (pixel !== BG || pix_valid_out !== 1'b0 || value_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_hold: pixel=%b pvo=%b ready=%b required %b 0 1", pixel, pix_valid_out, value_ready, BG);
            end
        end
        reset_n = 1'b1; pix_valid_in = 1'b0;
        cyc();
        for (int i = 0; i < 2; i++) begin
            probe(px[i], 1, p, pnz);
            n_checks++;
            if (p !== ep[i]) begin n_fail++; $display("FAIL reset_disp (%0d,1): pixel=%b required %b", px[i], p, ep[i]); end
            n_checks++;
            if (pnz !== en[i]) begin n_fail++; $display("FAIL reset_disp_nz (%0d,1): pixel=%b required %b", px[i], pnz, en[i]); end
        end
    endtask

    task automatic test_glyph();
        logic [5:0] p, pnz;
        int px[4] = '{17, 22, 22, 17};
        int py[4] = '{1, 3, 10, 10};
        logic [5:0] ep[4] = '{FG, BG, FG, BG};
        load(5);
        for (int i = 0; i < 4; i++) begin
            probe(px[i], py[i], p, pnz);
            n_checks++;
            if (p !== ep[i] || pnz !== ep[i]) begin
                n_fail++; $display("FAIL glyph5 (%0d,%0d): pixel=%b nz=%b required %b", px[i], py[i], p, pnz, ep[i]);
            end
        end
    endtask

    task automatic test_multi_digit();
        logic [5:0] p, pnz;
        int ax[4] = '{6, 1, 9, 17};
        int ay[4] = '{3, 3, 10, 10};
        logic [5:0] ae[4] = '{FG, BG, FG, BG};
        int bx[5] = '{1, 9, 3, 22, 17};
        int by[5] = '{1, 10, 7, 10, 10};
        logic [5:0] bp[5] = '{BG, BG, BG, FG, BG};
        logic [5:0] bn[5] = '{FG, FG, BG, FG, BG};
        load(123);
        for (int i = 0; i < 4; i++) begin
            probe(ax[i], ay[i], p, pnz);
            n_checks++;
            if (p !== ae[i] || pnz !== ae[i]) begin
                n_fail++; $display("FAIL multi123 (%0d,%0d): pixel=%b nz=%b required %b", ax[i], ay[i], p, pnz, ae[i]);
            end
        end
        load(7);
        for (int i = 0; i < 5; i++) begin
            probe(bx[i], by[i], p, pnz);
            n_checks++;
            if (p !== bp[i]) begin n_fail++; $display("FAIL multi7 (%0d,%0d): pixel=%b required %b", bx[i], by[i], p, bp[i]); end
            n_checks++;
            if (pnz !== bn[i]) begin n_fail++; $display("FAIL multi7_nz (%0d,%0d): pixel=%b required %b", bx[i], by[i], pnz, bn[i]); end
        end
    endtask

    task automatic test_overflow();
        logic [5:0] p, pnz;
        load(1000);
        for (int c = 0; c < 3; c++) begin
            for (int x = 1; x <= 6; x++) begin
                probe(c * 8 + x, 7, p, pnz);
                n_checks++;
                if (p !== FG || pnz !== FG) begin
                    n_fail++; $display("FAIL overflow_dash (%0d,7): pixel=%b nz=%b required %b", c * 8 + x, p, pnz, FG);
                end
            end
        end
        probe(1, 1, p, pnz);
        n_checks++;
        if (p !== BG || pnz !== BG) begin
            n_fail++; $display("FAIL overflow_top (1,1): pixel=%b nz=%b required %b", p, pnz, BG);
        end
    endtask

    task automatic test_commit();
        logic [5:0] p, pnz;
        int low_cnt;
        hcount = 10'd17; vcount = 10'd1; pix_valid_in = 1'b1;
        cyc(); cyc();
        value_in = VW'(8); value_valid = 1'b1;
        cyc();
        value_valid = 1'b0;
        low_cnt = (value_ready == 1'b0) ? 1 : 0;
        for (int i = 1; i <= VW + 5; i++) begin
            if (i == 3) begin value_in = VW'(456); value_valid = 1'b1; end
            else value_valid = 1'b0;
            cyc();
            if (value_ready == 1'b0) low_cnt++;
            n_checks++;
            if (pixel !== BG || pixel_nz !== BG) begin
                n_fail++; $display("FAIL commit_old cyc%0d: pixel=%b nz=%b required %b", i, pixel, pixel_nz, BG);
            end
        end
        value_valid = 1'b0;
        hcount = 10'd0; vcount = 10'd0;
        cyc();
        n_checks++;
        if (value_ready !== 1'b1) begin n_fail++; $display("FAIL commit_ready: value_ready=%b required 1", value_ready); end
        n_checks++;
        if (low_cnt != VW + 6) begin n_fail++; $display("FAIL ready_low_len: cycles=%0d required %0d", low_cnt, VW + 6); end
        n_checks++;
        if (pixel !== BG) begin n_fail++; $display("FAIL commit_last_old: pixel=%b required %b", pixel, BG); end
        hcount = 10'd17; vcount = 10'd1;
        cyc(); cyc();
        n_checks++;
        if (pixel !== FG || pixel_nz !== FG) begin
            n_fail++; $display("FAIL commit_new (17,1): pixel=%b nz=%b required %b", pixel, pixel_nz, FG);
        end
        pix_valid_in = 1'b0;
        probe(22, 3, p, pnz);
        n_checks++;
        if (p !== FG || pnz !== FG) begin n_fail++; $display("FAIL ignored_valid (22,3): pixel=%b nz=%b required %b", p, pnz, FG); end
        probe(3, 7, p, pnz);
        n_checks++;
        if (p !== BG || pnz !== BG) begin n_fail++; $display("FAIL ignored_valid (3,7): pixel=%b nz=%b required %b", p, pnz, BG); end
    endtask

    task automatic test_latency();
        logic exp_pv[3] = '{1'b0, 1'b1, 1'b0};
        pix_valid_in = 1'b0;
        cyc(); cyc();
        hcount = 10'd5; vcount = 10'd5; pix_valid_in = 1'b1;
        cyc();
        pix_valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) cyc();
            n_checks++;
            if (pix_valid_out !== exp_pv[i] || pix_valid_out_nz !== exp_pv[i]) begin
                n_fail++; $display("FAIL latency +%0d: pix_valid_out=%b required %b", i + 1, pix_valid_out, exp_pv[i]);
            end
        end
    endtask

    task automatic test_reset_mid_convert();
        logic [5:0] p, pnz;
        int px[3] = '{17, 20, 1};
        int py[3] = '{10, 7, 1};
        logic [5:0] ep[3] = '{FG, BG, BG};
        logic [5:0] en[3] = '{FG, BG, FG};
        value_in = VW'(9); value_valid = 1'b1;
        cyc();
        value_valid = 1'b0;
        repeat (3) cyc();
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (value_ready !== 1'b1 || pixel !== BG) begin
            n_fail++; $display("FAIL mid_reset: ready=%b pixel=%b required 1 %b", value_ready, pixel, BG);
        end
        cyc();
        reset_n = 1'b1;
        hcount = 10'd0; vcount = 10'd0; pix_valid_in = 1'b1;
        repeat (15) cyc();
        pix_valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            probe(px[i], py[i], p, pnz);
            n_checks++;
            if (p !== ep[i]) begin n_fail++; $display("FAIL after_reset (%0d,%0d): pixel=%b required %b", px[i], py[i], p, ep[i]); end
            n_checks++;
            if (pnz !== en[i]) begin n_fail++; $display("FAIL after_reset_nz (%0d,%0d): pixel=%b required %b", px[i], py[i], pnz, en[i]); end
        end
        n_checks++;
        if (value_ready !== 1'b1) begin n_fail++; $display("FAIL after_reset_ready: value_ready=%b required 1", value_ready); end
    endtask

    initial begin
        test_reset();
        test_glyph();
        test_multi_digit();
        test_overflow();
        test_commit();
        test_latency();
        test_reset_mid_convert();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/digit_value_renderer.md
# digit_value_renderer

Renders an unsigned binary value as a row of `NUM_DIGITS` decimal glyphs into the 6-bit pixel stream of the display path. The block sits between the height measurement logic and the video pixel mux. It converts each accepted value to BCD with a sequential double-dabble engine and commits it at a frame boundary so the picture never tears. It generalises the single-digit glyph ROM to all digits 0–9 plus a dash, with integer scaling, leading-zero blanking and overflow indication.

## Interface
Parameters:
- `VALUE_W`, 10: width of the binary input value.
- `NUM_DIGITS`, 3: number of decimal digit cells, 1–5.
- `SCALE_LOG2`, 1: glyph magnification is 2^SCALE_LOG2 in both axes.
- `ORIGIN_X`, 0 / `ORIGIN_Y`, 0: top-left pixel of the digit field.
- `LZ_BLANK`, 1: 1 blanks leading zeros; the least significant digit is always drawn.
- `FG`, 6'b000000 / `BG`, 6'b111111: glyph colour and background colour.

Ports:
- `clk` in 1: the single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `value_in` in VALUE_W: value to display.
- `value_valid` in 1: `value_in` is offered.
- `value_ready` out 1: the converter can accept a value.
- `hcount` in 10: pixel x coordinate.
- `vcount` in 10: pixel y coordinate.
- `pix_valid_in` in 1: the coordinates are valid this cycle.
- `pixel` out 6: colour for the pixel presented two cycles earlier.
- `pix_valid_out` out 1: `pix_valid_in` delayed by 2.

## Operation
- **Cell geometry.** Each cell is 8 cols × 16 rows in glyph space. Cell k (k=0 is leftmost, most significant) spans x ∈ [ORIGIN_X + k·8·S, ORIGIN_X + (k+1)·8·S), where S = 2^SCALE_LOG2. The field spans y ∈ [ORIGIN_Y, ORIGIN_Y + 16·S). Glyph col = (x offset within cell) >> SCALE_LOG2; glyph row = (y − ORIGIN_Y) >> SCALE_LOG2.
- **Segments.** A segment pixel is FG; every other pixel is BG.
  - a: rows 1–2, cols 1–6
  - g: rows 7–8, cols 1–6
  - d: rows 13–14, cols 1–6
  - f: rows 1–8, col 1
  - b: rows 1–8, col 6
  - e: rows 8–14, col 1
  - c: rows 8–14, col 6
- **Digit encoding** (standard seven-segment):
  - 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg
  - 5=acdfg, 6=acdefg, 7=abc, 8=all segments, 9=abcdfg
  - dash = g; blank = no segments
- **Outside the field:** BG.
- **Value FSM** (IDLE, CONVERT, HOLD):
  - IDLE: `value_ready`=1. When `value_valid`=1, capture `value_in` and set an overflow flag if value_in > 10^NUM_DIGITS − 1. Clear the BCD shift register, then go to CONVERT.
  - CONVERT: one double-dabble step per cycle (add 3 to each nibble ≥5, then shift left) for exactly VALUE_W cycles, then go to HOLD.
  - HOLD: wait for a frame-start pixel, i.e. `pix_valid_in`=1 with hcount=0 and vcount=0. On that edge, copy the BCD digits and the overflow flag into the display register, then return to IDLE.
  - `value_ready`=0 in CONVERT and HOLD. `value_valid` is ignored there, and the pending value is not replaced.
- **Display mapping:**
  - Overflow set: every cell shows a dash.
  - Otherwise, with LZ_BLANK=1: zero digits to the left of the first nonzero digit are blank, except cell NUM_DIGITS−1.
- **Reset.**
  - State goes to IDLE and the display register to all zeros: the field shows "0" in the rightmost cell, or "000" with LZ_BLANK=0.
  - Pipeline registers clear.
  - A reset during CONVERT or HOLD discards the pending value.

## Timing
- Reset values: `pixel`=BG, `pix_valid_out`=0, `value_ready`=1.
- **Pixel pipeline latency is 2 cycles, fully pipelined**, with one pixel per cycle.
  - Stage 1 registers the cell index, glyph row/col and the in-field flag.
  - Stage 2 registers `pixel` from the display register.
  - When `pix_valid_in`=0, `pixel` is BG.
- Accept edge T: CONVERT runs over cycles T+1 … T+VALUE_W, and HOLD is entered at T+VALUE_W+1. The earliest commit is the first frame-start pixel at or after that edge.
- **Commit rule:** the frame-start pixel and every later pixel use the new value; all earlier pixels use the old value.
- `value_ready` rises on the edge after commit. A simultaneous valid in that same cycle is accepted.

## Test plan
- **Reset.** Hold `reset_n`=0 for 3 cycles, then stream a frame with NUM_DIGITS=3, SCALE_LOG2=0, origin 0, LZ_BLANK=1. Expect `pixel`=BG and `pix_valid_out`=0 during reset, and `value_ready`=1. Expect (17,1)=FG (cell 2 segment a) and (1,1)=BG (cell 0 blank).
- **Glyph check.** Load 5 and pass a frame start. Expect (17,1)=FG, (22,3)=BG (b absent), (22,10)=FG (c) and (17,10)=BG (e absent).
- **Multi-digit.** Load 123. Expect cell 0 at (6,3)=FG with (1,3)=BG (digit 1), and cell 1 at (9,10)=FG (digit 2, segment e). Load 7 with LZ_BLANK=0: cells 0 and 1 show '0'.
- **Overflow.** Load 1000. Expect (x,7)=FG for x ∈ {1..6, 9..14, 17..22} and (1,1)=BG.
- **Commit and handshake.**
  - Load 8 at mid-frame. Pixels remain old until the next frame start, then all show the new value.
  - `value_ready` is low for exactly VALUE_W+1+wait cycles.
  - A second `value_valid` during CONVERT is ignored.
- **Latency and reset mid-conversion.**
  - A single `pix_valid_in` pulse yields `pix_valid_out` exactly 2 cycles later.
  - Assert `reset_n` low during CONVERT. The display shows "0" afterwards and `value_ready`=1.
